mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-ported data block RAM between the CPU load/store path and the display scanout reader. It sits between the controller/datapath memory port and the BRAM. It issues at most one access per cycle and tracks in-flight reads in a tagged pipeline. Each read result is returned only to the requester that issued it.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported data BRAM between the CPU load/store
// path and the display scanout reader. At most one access is issued per
// cycle through a registered issue stage. Every read carries a {valid, owner}
// tag through a READ_LAT+1 deep shift pipeline, so each result goes back only
// to the requester that issued it.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration between
// contending requesters. Left undefined, arbitration is fixed priority with
// the display ahead of the CPU.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  CPU request, held until cpu_gnt
//   cpu_gnt             combinational accept for the CPU
//   cpu_rvalid/rdata    one-cycle read return pulse and data for the CPU
//   vid_req/addr        display read request, held until vid_gnt
//   vid_gnt             combinational accept for the display
//   vid_rvalid/rdata    one-cycle read return pulse and data for the display
//   mem_addr/wdata/we   registered BRAM command
//   mem_rdata           BRAM data, valid READ_LAT cycles after mem_addr
module mem_arbiter #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16,
  parameter int READ_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [WIDTH-1:0]     cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [WIDTH-1:0]     cpu_rdata,
  input  logic                 vid_req,
  input  logic [ADDR_BITS-1:0] vid_addr,
  output logic                 vid_gnt,
  output logic                 vid_rvalid,
  output logic [WIDTH-1:0]     vid_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 mem_we,
  input  logic [WIDTH-1:0]     mem_rdata
);

  localparam int DEPTH = READ_LAT + 1;

  typedef enum logic {LAST_CPU, LAST_VID} last_t;

  // owner: 1 = display, 0 = CPU
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  last_t last_q, last_d;
  tag_t  tags [DEPTH];
  logic  accept_read;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= LAST_VID;
    end else begin
      last_q <= last_d;
    end
  end

  // Grants are suppressed while reset is asserted so nothing is accepted
  // while the pipeline is being cleared.
  always_comb begin
    cpu_gnt = 1'b0;
    vid_gnt = 1'b0;
    last_d  = last_q;
    if (reset) begin
`ifdef MEM_ARB_RR_EN
      if (cpu_req && vid_req) begin
        if (last_q == LAST_CPU) begin
          vid_gnt = 1'b1;
        end else begin
          cpu_gnt = 1'b1;
        end
      end else begin
        cpu_gnt = cpu_req;
        vid_gnt = vid_req;
      end
`else
      vid_gnt = vid_req;
      cpu_gnt = cpu_req && !vid_req;
`endif
    end
    if (cpu_gnt) begin
      last_d = LAST_CPU;
    end else if (vid_gnt) begin
      last_d = LAST_VID;
    end
  end

  assign accept_read = vid_gnt || (cpu_gnt && !cpu_we);

  // Issue register: mem_we is a one-cycle strobe, mem_addr holds when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (vid_gnt) begin
        mem_addr <= vid_addr;
      end else if (cpu_gnt) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_we    <= cpu_we;
      end
    end
  end

  // A tag leaves the last stage in the same cycle the BRAM presents its
  // data, so the capture below lines up with mem_rdata without a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0].valid <= accept_read;
      tags[0].owner <= vid_gnt;
      for (int i = 1; i < DEPTH; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rvalid <= 1'b0;
      vid_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      vid_rdata  <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      vid_rvalid <= 1'b0;
      if (tags[DEPTH-1].valid) begin
        if (tags[DEPTH-1].owner) begin
          vid_rvalid <= 1'b1;
          vid_rdata  <= mem_rdata;
        end else begin
          cpu_rvalid <= 1'b1;
          cpu_rdata  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives two mem_arbiter instances (READ_LAT = 1 and 3) with
// identical request streams and checks them against a transaction-level model:
// a shadow memory updated in acceptance order plus a log of expected read
// returns. A separate monitor consumes that log when the DUTs return data.
module tb_mem_arbiter;

  localparam int NI = 2;

  typedef struct {
    int          e0;
    bit          owner;
    logic [15:0] data;
  } ret_t;

  typedef struct {
    int          e0;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wd;
  } iss_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        vid_req = 1'b0;
  logic [15:0] vid_addr = '0;

  logic        cpu_gnt [NI];
  logic        cpu_rvalid [NI];
  logic [15:0] cpu_rdata [NI];
  logic        vid_gnt [NI];
  logic        vid_rvalid [NI];
  logic [15:0] vid_rdata [NI];
  logic [15:0] mem_addr [NI];
  logic [15:0] mem_wdata [NI];
  logic        mem_we [NI];
  logic [15:0] mem_rdata [NI];

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [15:0] ref_mem [65536];
  ret_t        ret_log [$];
  iss_t        iss_q [$];
  int          head [NI];
  logic [15:0] exp_crd [NI];
  logic [15:0] exp_vrd [NI];
  bit          last_was_cpu = 1'b0;
  bit          cpu_taken, vid_taken;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input int a);
    logic [15:0] w;
    w = 16'(a) ^ 16'hA5C3;
    if (a == 32'h0100) w = 16'h1111;
    if (a == 32'h0200) w = 16'h2222;
    return w;
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : inst
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [15:0] bram [65536];
      logic [15:0] rpipe [4];

      mem_arbiter #(.WIDTH(16), .ADDR_BITS(16), .READ_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt[g]),
        .cpu_rvalid (cpu_rvalid[g]),
        .cpu_rdata  (cpu_rdata[g]),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt[g]),
        .vid_rvalid (vid_rvalid[g]),
        .vid_rdata  (vid_rdata[g]),
        .mem_addr   (mem_addr[g]),
        .mem_wdata  (mem_wdata[g]),
        .mem_we     (mem_we[g]),
        .mem_rdata  (mem_rdata[g])
      );

      // BRAM model: read-before-write, LAT cycles from address to data.
      initial begin
        for (int i = 0; i < 65536; i++) bram[i] <= init_word(i);
        for (int k = 0; k < 4; k++) rpipe[k] <= '0;
        forever begin
          @(posedge clk);
          rpipe[0] <= bram[mem_addr[g]];
          for (int k = 1; k < 4; k++) rpipe[k] <= rpipe[k-1];
          if (mem_we[g]) bram[mem_addr[g]] <= mem_wdata[g];
        end
      end

      assign mem_rdata[g] = rpipe[LAT-1];
    end
  endgenerate

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cyc, actual, expected);
    end
  endtask

  // Drive one cycle of requests, predict the grants from the arbitration
  // rules, and record what the accepting edge should produce.
  task automatic apply_stimulus(input bit c_req, input bit c_we,
                                input logic [15:0] c_addr,
                                input logic [15:0] c_wd,
                                input bit v_req, input logic [15:0] v_addr);
    bit   ev, ec;
    iss_t is;
    ret_t rt;
    @(negedge clk);
    cpu_req = c_req;  cpu_we = c_we;  cpu_addr = c_addr;  cpu_wdata = c_wd;
    vid_req = v_req;  vid_addr = v_addr;
    #1;
`ifdef MEM_ARB_RR_EN
    if (c_req && v_req) begin
      ev = last_was_cpu;
      ec = !last_was_cpu;
    end else begin
      ev = v_req;
      ec = c_req;
    end
`else
    ev = v_req;
    ec = c_req && !v_req;
`endif
    for (int i = 0; i < NI; i++) begin
      check_output("vid_gnt", 32'(vid_gnt[i]), 32'(ev));
      check_output("cpu_gnt", 32'(cpu_gnt[i]), 32'(ec));
    end
    is.e0 = cyc + 1;
    rt.e0 = cyc + 1;
    if (ev) begin
      is.we = 1'b0;  is.addr = v_addr;  is.wd = '0;
      rt.owner = 1'b1;  rt.data = ref_mem[v_addr];
      iss_q.push_back(is);
      ret_log.push_back(rt);
      last_was_cpu = 1'b0;
    end else if (ec) begin
      is.we = c_we;  is.addr = c_addr;  is.wd = c_wd;
      iss_q.push_back(is);
      if (c_we) begin
        ref_mem[c_addr] = c_wd;
      end else begin
        rt.owner = 1'b0;  rt.data = ref_mem[c_addr];
        ret_log.push_back(rt);
      end
      last_was_cpu = 1'b1;
    end
    cpu_taken = ec;
    vid_taken = ev;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset   = 1'b0;
    cpu_req = 1'b1;
    vid_req = 1'b1;
    for (int i = 0; i < NI; i++) begin
      head[i]    = ret_log.size();
      exp_crd[i] = '0;
      exp_vrd[i] = '0;
    end
    iss_q.delete();
    last_was_cpu = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        check_output("rst_gnt", {30'd0, cpu_gnt[i], vid_gnt[i]}, 32'd0);
        check_output("rst_rvalid", {30'd0, cpu_rvalid[i], vid_rvalid[i]}, 32'd0);
        check_output("rst_rdata", {cpu_rdata[i], vid_rdata[i]}, 32'd0);
        check_output("rst_mem", {mem_addr[i], mem_wdata[i]}, 32'd0);
        check_output("rst_mem_we", 32'(mem_we[i]), 32'd0);
      end
    end
    @(negedge clk);
    reset   = 1'b1;
    cpu_req = 1'b0;
    vid_req = 1'b0;
  endtask

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  initial begin
    bit   have;
    iss_t is;
    ret_t rt;
    int   due;
    forever begin
      @(posedge clk);
      #1;
      have = (iss_q.size() > 0) && (iss_q[0].e0 == cyc);
      if (have) is = iss_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        check_output("mem_we", 32'(mem_we[i]), 32'(have && is.we));
        if (have) begin
          check_output("mem_addr", 32'(mem_addr[i]), 32'(is.addr));
          if (is.we) check_output("mem_wdata", 32'(mem_wdata[i]), 32'(is.wd));
        end
        due = (head[i] < ret_log.size()) ? ret_log[head[i]].e0 + lat_of(i) + 1 : -1;
        if (cpu_rvalid[i] || vid_rvalid[i]) begin
          if (due == cyc) begin
            rt = ret_log[head[i]];
            head[i]++;
            check_output("rvalid_owner", {30'd0, vid_rvalid[i], cpu_rvalid[i]},
                         rt.owner ? 32'd2 : 32'd1);
            if (rt.owner) exp_vrd[i] = rt.data;
            else          exp_crd[i] = rt.data;
            check_output("vid_rdata", 32'(vid_rdata[i]), 32'(exp_vrd[i]));
            check_output("cpu_rdata", 32'(cpu_rdata[i]), 32'(exp_crd[i]));
          end else begin
            check_output("unexpected_rvalid", 32'd1, 32'd0);
          end
        end else if (due != -1 && due <= cyc) begin
          check_output("missing_rvalid", 32'd0, 32'd1);
          head[i]++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          cp, vp, cwe;
    logic [15:0] caddr, cwd, vaddr;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);

    do_reset(3);

    $display("[TB] cpu write then read");
    apply_stimulus(1, 1, 16'h0010, 16'hBEEF, 0, 16'h0);
    apply_stimulus(1, 0, 16'h0010, 16'h0, 0, 16'h0);
    repeat (5) apply_stimulus(0, 0, 16'h0, 16'h0, 0, 16'h0);

    $display("[TB] contention");
    caddr = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 0, caddr, 16'h0, 1, 16'h0100 + 16'(k));
      if (cpu_taken) caddr = caddr + 16'h1;
    end
    apply_stimulus(1, 0, caddr, 16'h0, 0, 16'h0);
    repeat (5) apply_stimulus(0, 0, 16'h0, 16'h0, 0, 16'h0);

    $display("[TB] interleaved returns");
    apply_stimulus(0, 0, 16'h0, 16'h0, 1, 16'h0100);
    apply_stimulus(1, 0, 16'h0200, 16'h0, 0, 16'h0);
    apply_stimulus(0, 0, 16'h0, 16'h0, 1, 16'h0100);
    apply_stimulus(1, 0, 16'h0200, 16'h0, 0, 16'h0);
    repeat (5) apply_stimulus(0, 0, 16'h0, 16'h0, 0, 16'h0);

    $display("[TB] back-to-back display reads");
    for (int k = 0; k < 4; k++)
      apply_stimulus(0, 0, 16'h0, 16'h0, 1, 16'h0300 + 16'(k));
    repeat (6) apply_stimulus(0, 0, 16'h0, 16'h0, 0, 16'h0);

    $display("[TB] reset with reads in flight");
    apply_stimulus(0, 0, 16'h0, 16'h0, 1, 16'h0100);
    do_reset(2);
    repeat (6) apply_stimulus(0, 0, 16'h0, 16'h0, 0, 16'h0);

    $display("[TB] random traffic");
    cp = 1'b0;  vp = 1'b0;
    cwe = 1'b0;  caddr = '0;  cwd = '0;  vaddr = '0;
    repeat (300) begin
      if (!cp && $urandom_range(0, 3) != 0) begin
        cp    = 1'b1;
        cwe   = 1'($urandom_range(0, 1));
        caddr = 16'($urandom_range(0, 15));
        cwd   = 16'($urandom);
      end
      if (!vp && $urandom_range(0, 2) == 0) begin
        vp    = 1'b1;
        vaddr = 16'($urandom_range(0, 15));
      end
      apply_stimulus(cp, cwe, caddr, cwd, vp, vaddr);
      if (cpu_taken) cp = 1'b0;
      if (vid_taken) vp = 1'b0;
    end
    repeat (8) apply_stimulus(0, 0, 16'h0, 16'h0, 0, 16'h0);

    for (int i = 0; i < NI; i++)
      check_output("returns_drained", 32'(head[i]), 32'(ret_log.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
